rs_station: RTL and testbench

- Reservation station between dispatch and the ALU in the Tomasulo core.
- Buffers decoded ALU ops whose source operands may still be pending on ROB tags.
- Snoops three broadcast buses (ALU CDB, LSB CDB, ROB commit) to wake up operands.
- Issues one ready entry per cycle to the ALU over a registered interface.

---
 rtl/rs_station.sv | 216 +++++++++++++++++++++
 tb/tb_rs_station.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station.sv
// Reservation station feeding the ALU: buffers ops, snoops three broadcast buses, issues one ready op per cycle.
// Optional RS_OLDEST_FIRST_EN: issue the oldest ready entry instead of the lowest-index one.
module rs_station #(
    parameter int RS_SIZE  = 16,
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                disp_valid,
    input  logic [OP_W-1:0]     disp_op,
    input  logic [DATA_W-1:0]   disp_v1,
    input  logic [DATA_W-1:0]   disp_v2,
    input  logic                disp_p1,
    input  logic                disp_p2,
    input  logic [ROB_ID_W-1:0] disp_q1,
    input  logic [ROB_ID_W-1:0] disp_q2,
    input  logic [DATA_W-1:0]   disp_imm,
    input  logic [DATA_W-1:0]   disp_pc,
    input  logic [ROB_ID_W-1:0] disp_rob_id,
    input  logic                cdb1_valid,
    input  logic [ROB_ID_W-1:0] cdb1_rob_id,
    input  logic [DATA_W-1:0]   cdb1_value,
    input  logic                cdb2_valid,
    input  logic [ROB_ID_W-1:0] cdb2_rob_id,
    input  logic [DATA_W-1:0]   cdb2_value,
    input  logic                cdb3_valid,
    input  logic [ROB_ID_W-1:0] cdb3_rob_id,
    input  logic [DATA_W-1:0]   cdb3_value,
    output logic                rs_full,
    output logic                alu_valid,
    output logic [OP_W-1:0]     alu_op,
    output logic [DATA_W-1:0]   alu_v1,
    output logic [DATA_W-1:0]   alu_v2,
    output logic [DATA_W-1:0]   alu_imm,
    output logic [DATA_W-1:0]   alu_pc,
    output logic [ROB_ID_W-1:0] alu_rob_id
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]  busy_r, p1_r, p2_r;
    logic [OP_W-1:0]     op_r  [RS_SIZE];
    logic [DATA_W-1:0]   v1_r  [RS_SIZE];
    logic [DATA_W-1:0]   v2_r  [RS_SIZE];
    logic [ROB_ID_W-1:0] q1_r  [RS_SIZE];
    logic [ROB_ID_W-1:0] q2_r  [RS_SIZE];
    logic [DATA_W-1:0]   imm_r [RS_SIZE];
    logic [DATA_W-1:0]   pc_r  [RS_SIZE];
    logic [ROB_ID_W-1:0] rob_r [RS_SIZE];

    logic                alu_valid_r;
    logic [OP_W-1:0]     alu_op_r;
    logic [DATA_W-1:0]   alu_v1_r, alu_v2_r, alu_imm_r, alu_pc_r;
    logic [ROB_ID_W-1:0] alu_rob_r;

    logic                rs_full_s, disp_fire_s, sel_found_s;
    logic [IDX_W-1:0]    free_idx_s, sel_idx_s;
    logic [RS_SIZE-1:0]  ready_s;

    // Resolve one operand against the broadcast buses; returns {pending, value}, priority cdb2 > cdb1 > cdb3.
    function automatic logic [DATA_W:0] snoop(input logic p, input logic [ROB_ID_W-1:0] q,
                                              input logic [DATA_W-1:0] v);
        logic [DATA_W:0] r;
        if (!p) begin
            r = {1'b0, v};
        end else if (cdb2_valid && (cdb2_rob_id == q)) begin
            r = {1'b0, cdb2_value};
        end else if (cdb1_valid && (cdb1_rob_id == q)) begin
            r = {1'b0, cdb1_value};
        end else if (cdb3_valid && (cdb3_rob_id == q)) begin
            r = {1'b0, cdb3_value};
        end else begin
            r = {1'b1, v};
        end
        return r;
    endfunction

    assign rs_full     = rs_full_s;
    assign rs_full_s   = &busy_r;
    assign ready_s     = busy_r & ~p1_r & ~p2_r;
    assign disp_fire_s = rdy & ~rollback & disp_valid & ~rs_full_s;

    assign alu_valid  = alu_valid_r;
    assign alu_op     = alu_op_r;
    assign alu_v1     = alu_v1_r;
    assign alu_v2     = alu_v2_r;
    assign alu_imm    = alu_imm_r;
    assign alu_pc     = alu_pc_r;
    assign alu_rob_id = alu_rob_r;

    // Lowest-index free slot from the registered busy bits
    always_comb begin
        free_idx_s = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            free_idx_s = busy_r[i] ? free_idx_s : IDX_W'(i);
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    localparam int AGE_W = IDX_W + 2;
    logic [AGE_W-1:0] age_r [RS_SIZE];
    logic [AGE_W-1:0] age_cnt_r;

    // a is older than b when the wrapped difference a-b is negative
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = a - b;
        return d[AGE_W-1];
    endfunction

    // Oldest ready entry by age stamp
    always_comb begin
        sel_idx_s   = '0;
        sel_found_s = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_s[i] && (!sel_found_s || older(age_r[i], age_r[sel_idx_s]))) begin
                sel_idx_s   = IDX_W'(i);
                sel_found_s = 1'b1;
            end else begin
                sel_idx_s   = sel_idx_s;
                sel_found_s = sel_found_s;
            end
        end
    end
`else
    // Lowest-index ready entry
    always_comb begin
        sel_idx_s = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            sel_idx_s = ready_s[i] ? IDX_W'(i) : sel_idx_s;
        end
        sel_found_s = |ready_s;
    end
`endif

    // Entry table: wakeup, issue, dispatch and the registered ALU interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= '0;
            p1_r        <= '0;
            p2_r        <= '0;
            alu_valid_r <= 1'b0;
            alu_op_r    <= '0;
            alu_v1_r    <= '0;
            alu_v2_r    <= '0;
            alu_imm_r   <= '0;
            alu_pc_r    <= '0;
            alu_rob_r   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]  <= '0;
                v1_r[i]  <= '0;
                v2_r[i]  <= '0;
                q1_r[i]  <= '0;
                q2_r[i]  <= '0;
                imm_r[i] <= '0;
                pc_r[i]  <= '0;
                rob_r[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
                age_r[i] <= '0;
`endif
            end
`ifdef RS_OLDEST_FIRST_EN
            age_cnt_r <= '0;
`endif
        end else if (!rdy) begin
            alu_valid_r <= 1'b0;
        end else if (rollback) begin
            busy_r      <= '0;
            alu_valid_r <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
            age_cnt_r <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                age_r[i] <= '0;
            end
`endif
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_r[i]) begin
                    {p1_r[i], v1_r[i]} <= snoop(p1_r[i], q1_r[i], v1_r[i]);
                    {p2_r[i], v2_r[i]} <= snoop(p2_r[i], q2_r[i], v2_r[i]);
                end
            end
            if (sel_found_s) begin
                busy_r[sel_idx_s] <= 1'b0;
                alu_valid_r       <= 1'b1;
                alu_op_r          <= op_r[sel_idx_s];
                alu_v1_r          <= v1_r[sel_idx_s];
                alu_v2_r          <= v2_r[sel_idx_s];
                alu_imm_r         <= imm_r[sel_idx_s];
                alu_pc_r          <= pc_r[sel_idx_s];
                alu_rob_r         <= rob_r[sel_idx_s];
            end else begin
                alu_valid_r <= 1'b0;
            end
            // The selected slot is still busy here, so dispatch never lands on it
            if (disp_fire_s) begin
                busy_r[free_idx_s] <= 1'b1;
                op_r[free_idx_s]   <= disp_op;
                q1_r[free_idx_s]   <= disp_q1;
                q2_r[free_idx_s]   <= disp_q2;
                imm_r[free_idx_s]  <= disp_imm;
                pc_r[free_idx_s]   <= disp_pc;
                rob_r[free_idx_s]  <= disp_rob_id;
                {p1_r[free_idx_s], v1_r[free_idx_s]} <= snoop(disp_p1, disp_q1, disp_v1);
                {p2_r[free_idx_s], v2_r[free_idx_s]} <= snoop(disp_p2, disp_q2, disp_v2);
`ifdef RS_OLDEST_FIRST_EN
                age_r[free_idx_s] <= age_cnt_r;
                age_cnt_r         <= age_cnt_r + AGE_W'(1);
`endif
            end
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// Directed self-checking bench for rs_station with hand-computed expectations.
module tb_rs_station;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        disp_valid, disp_p1, disp_p2;
    logic [5:0]  disp_op;
    logic [31:0] disp_v1, disp_v2, disp_imm, disp_pc;
    logic [3:0]  disp_q1, disp_q2, disp_rob_id;
    logic        cdb1_valid, cdb2_valid, cdb3_valid;
    logic [3:0]  cdb1_rob_id, cdb2_rob_id, cdb3_rob_id;
    logic [31:0] cdb1_value, cdb2_value, cdb3_value;
    logic        rs_full, alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_id;

    int n_checks = 0;
    int n_errors = 0;

    rs_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_p1(disp_p1), .disp_p2(disp_p2),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_imm(disp_imm), .disp_pc(disp_pc),
        .disp_rob_id(disp_rob_id),
        .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
        .cdb2_valid(cdb2_valid), .cdb2_rob_id(cdb2_rob_id), .cdb2_value(cdb2_value),
        .cdb3_valid(cdb3_valid), .cdb3_rob_id(cdb3_rob_id), .cdb3_value(cdb3_value),
        .rs_full(rs_full), .alu_valid(alu_valid), .alu_op(alu_op),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob_id(alu_rob_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] v1, input logic p1,
                            input logic [3:0] q1, input logic [31:0] v2, input logic p2,
                            input logic [3:0] q2, input logic [3:0] rob);
        disp_valid  = 1'b1;
        disp_op     = op;
        disp_v1     = v1;
        disp_p1     = p1;
        disp_q1     = q1;
        disp_v2     = v2;
        disp_p2     = p2;
        disp_q2     = q2;
        disp_rob_id = rob;
        disp_imm    = 32'h0000_1000 + {28'h0, rob};
        disp_pc     = 32'h0000_0400 + {26'h0, rob, 2'b00};
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb1_valid = 1'b0;
        cdb2_valid = 1'b0;
        cdb3_valid = 1'b0;
    endtask

    task automatic cdb(input int n, input logic [3:0] tag, input logic [31:0] val);
        case (n)
            1: begin cdb1_valid = 1'b1; cdb1_rob_id = tag; cdb1_value = val; end
            2: begin cdb2_valid = 1'b1; cdb2_rob_id = tag; cdb2_value = val; end
            3: begin cdb3_valid = 1'b1; cdb3_rob_id = tag; cdb3_value = val; end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        disp_valid = 1'b0; disp_op = '0; disp_v1 = '0; disp_v2 = '0; disp_p1 = 1'b0; disp_p2 = 1'b0;
        disp_q1 = '0; disp_q2 = '0; disp_imm = '0; disp_pc = '0; disp_rob_id = '0;
        cdb1_valid = 1'b0; cdb2_valid = 1'b0; cdb3_valid = 1'b0;
        cdb1_rob_id = '0; cdb2_rob_id = '0; cdb3_rob_id = '0;
        cdb1_value = '0; cdb2_value = '0; cdb3_value = '0;
        #12;
        check("reset_alu_valid", alu_valid, 1'b0);
        check("reset_rs_full", rs_full, 1'b0);
        check("reset_alu_v1", alu_v1, 32'h0);
        check("reset_alu_rob", alu_rob_id, 4'h0);
        tick();
        rst = 1'b0;

        // Ready-at-dispatch op
        dispatch(6'h01, 32'd5, 1'b0, 4'h0, 32'd7, 1'b0, 4'h0, 4'd3);
        tick();
        idle();
        check("ready_not_yet", alu_valid, 1'b0);
        tick();
        check("ready_valid", alu_valid, 1'b1);
        check("ready_v1", alu_v1, 32'd5);
        check("ready_v2", alu_v2, 32'd7);
        check("ready_rob", alu_rob_id, 4'd3);
        check("ready_op", alu_op, 6'h01);
        check("ready_imm", alu_imm, 32'h0000_1003);
        check("ready_pc", alu_pc, 32'h0000_040C);
        tick();
        check("ready_drop", alu_valid, 1'b0);
        check("ready_hold_v1", alu_v1, 32'd5);

        // Wakeup with dual match: cdb2 wins over cdb1
        dispatch(6'h02, 32'h0, 1'b1, 4'd9, 32'd3, 1'b0, 4'h0, 4'd5);
        tick();
        idle();
        cdb(1, 4'd9, 32'h11);
        cdb(2, 4'd9, 32'h22);
        tick();
        idle();
        check("wake_not_yet", alu_valid, 1'b0);
        tick();
        check("wake_valid", alu_valid, 1'b1);
        check("wake_v1", alu_v1, 32'h22);
        check("wake_v2", alu_v2, 32'd3);
        check("wake_rob", alu_rob_id, 4'd5);

        // Dispatch-cycle capture from cdb3
        dispatch(6'h03, 32'd1, 1'b0, 4'h0, 32'h0, 1'b1, 4'd4, 4'd6);
        cdb(3, 4'd4, 32'hAB);
        tick();
        idle();
        tick();
        check("cap_valid", alu_valid, 1'b1);
        check("cap_v2", alu_v2, 32'hAB);
        check("cap_rob", alu_rob_id, 4'd6);
        // Dispatch-cycle capture: cdb1 beats cdb3
        dispatch(6'h04, 32'h0, 1'b1, 4'd2, 32'h0, 1'b0, 4'h0, 4'd7);
        cdb(1, 4'd2, 32'h55);
        cdb(3, 4'd2, 32'h66);
        tick();
        idle();
        tick();
        check("cap2_valid", alu_valid, 1'b1);
        check("cap2_v1", alu_v1, 32'h55);

        // Fill all 16 entries with ops pending on tag 10
        for (int i = 0; i < 16; i++) begin
            dispatch(6'h05, 32'h0, 1'b1, 4'd10, i, 1'b0, 4'h0, 4'(i));
            tick();
            if (i == 14) check("fill_not_full", rs_full, 1'b0);
        end
        idle();
        check("fill_full", rs_full, 1'b1);
        dispatch(6'h06, 32'hDEAD, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'd14);
        tick();
        idle();
        check("over_full", rs_full, 1'b1);
        check("over_no_issue", alu_valid, 1'b0);
        tick();
        check("over_dropped", alu_valid, 1'b0);

        // Stall with a matching broadcast: nothing may change
        rdy = 1'b0;
        cdb(1, 4'd10, 32'h77);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", alu_valid, 1'b0);
            check("stall_full", rs_full, 1'b1);
        end
        rdy = 1'b1;
        idle();
        tick();
        check("stall_no_wake", alu_valid, 1'b0);
        cdb(1, 4'd10, 32'h77);
        tick();
        idle();
        tick();
        check("fill_issue_valid", alu_valid, 1'b1);
        check("fill_issue_rob", alu_rob_id, 4'd0);
        check("fill_issue_v1", alu_v1, 32'h77);
        check("fill_freed", rs_full, 1'b0);

        // Rollback flushes the remaining 15 ready entries
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("rb_valid", alu_valid, 1'b0);
        check("rb_full", rs_full, 1'b0);
        tick();
        check("rb_empty", alu_valid, 1'b0);

        // Select policy: entry 5 older than re-dispatched entry 2
        for (int i = 0; i < 6; i++) begin
            dispatch(6'h07, 32'h0, 1'b1, (i == 2) ? 4'd13 : ((i == 5) ? 4'd14 : 4'd12),
                     32'h0, 1'b0, 4'h0, 4'(i));
            tick();
        end
        idle();
        cdb(1, 4'd13, 32'h13);
        tick();
        idle();
        tick();
        check("sel_pre_rob", alu_rob_id, 4'd2);
        dispatch(6'h08, 32'h0, 1'b1, 4'd15, 32'h0, 1'b0, 4'h0, 4'd9);
        tick();
        idle();
        cdb(1, 4'd14, 32'h14);
        cdb(2, 4'd15, 32'h15);
        tick();
        idle();
        tick();
`ifdef RS_OLDEST_FIRST_EN
        check("sel_first_rob", alu_rob_id, 4'd5);
        check("sel_first_v1", alu_v1, 32'h14);
`else
        check("sel_first_rob", alu_rob_id, 4'd9);
        check("sel_first_v1", alu_v1, 32'h15);
`endif
        tick();
        check("sel_second_valid", alu_valid, 1'b1);
`ifdef RS_OLDEST_FIRST_EN
        check("sel_second_rob", alu_rob_id, 4'd9);
`else
        check("sel_second_rob", alu_rob_id, 4'd5);
`endif
        tick();
        check("sel_done", alu_valid, 1'b0);

        // Asynchronous reset while an issue is on the outputs
        dispatch(6'h09, 32'h99, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'd7);
        tick();
        idle();
        tick();
        check("ar_pre_valid", alu_valid, 1'b1);
        check("ar_pre_v1", alu_v1, 32'h99);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", alu_valid, 1'b0);
        check("ar_full", rs_full, 1'b0);
        check("ar_rob", alu_rob_id, 4'h0);
        check("ar_v1", alu_v1, 32'h0);
        #1;
        rst = 1'b0;
        cdb(1, 4'd12, 32'h12);
        tick();
        idle();
        tick();
        check("ar_cleared", alu_valid, 1'b0);
        dispatch(6'h0A, 32'h1, 1'b0, 4'h0, 32'h2, 1'b0, 4'h0, 4'd1);
        tick();
        idle();
        tick();
        check("ar_after_valid", alu_valid, 1'b1);
        check("ar_after_rob", alu_rob_id, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
